// File: rtl/trig_pkg.sv
// Shared constants, types and ROM-content helper for the sine/cosine lookup pipeline.
package trig_pkg;

  localparam int unsigned ANGLE_W    = 10;
  localparam int unsigned DATA_W     = 21;
  localparam int unsigned FRAC_BITS  = 10;
  localparam int unsigned QTR        = 256;
  localparam int unsigned QTR_W      = 8;
  localparam int unsigned LUT_DEPTH  = 257;
  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned LAT        = 2;

  localparam int unsigned REQ_PLAYER = 0;
  localparam int unsigned REQ_WALLS  = 1;
  localparam int unsigned REQ_SPOKES = 2;
  localparam int unsigned REQ_SPARE  = 3;

  typedef logic [ANGLE_W-1:0]        angle_t;
  typedef logic signed [DATA_W-1:0]  trig_t;

  // pi in Q30 fixed point
  localparam longint PI_Q30 = 64'sd3373259426;

  // round(2^FRAC_BITS * sin(i*pi/512)) via a Q30 Taylor series, evaluated at elaboration
  function automatic trig_t sin_entry(input int unsigned i);
    longint x;
    longint x2;
    longint term;
    longint acc;
    x    = (longint'(i) * PI_Q30) / longint'(2 * QTR);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n < 12; n++) begin
      term = ((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      if (n % 2 == 1) acc = acc - term;
      else            acc = acc + term;
    end
    return DATA_W'((acc * longint'(1 << FRAC_BITS) + (longint'(1) <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/trig_lut.sv
// Quarter-wave sine/cosine ROM with quadrant fold; fixed two-clock latency with a
// pass-through tag (zero when no result), usable standalone with TAG_W=1.
module trig_lut
  import trig_pkg::*;
#(
  parameter int unsigned TAG_W = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  input  logic [TAG_W-1:0]         in_tag_i,
  input  logic [ANGLE_W-1:0]       angle_i,
  input  logic                     is_cos_i,
  output logic [TAG_W-1:0]         out_tag_o,
  output logic signed [DATA_W-1:0] out_data_o,
  output logic                     busy_o
);

  trig_t rom [LUT_DEPTH];

  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_rom
    localparam trig_t ENTRY = sin_entry(g);
    assign rom[g] = ENTRY;
  end

  logic [ANGLE_W-1:0] eff_c;
  logic [1:0]         quad_c;
  logic [QTR_W-1:0]   idx_c;

  logic               s1_vld_q, s1_vld_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic               s1_neg_q, s1_neg_d;
  logic [ADDR_W-1:0]  s1_addr_q, s1_addr_d;

  logic               s2_vld_q, s2_vld_d;
  logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;
  logic               s2_neg_q, s2_neg_d;
  trig_t              s2_mag_q, s2_mag_d;

  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  trig_t              out_data_q, out_data_d;

  // Fold the effective angle into a 0..256 table address plus a sign
  always_comb begin
    eff_c     = is_cos_i ? angle_i + ANGLE_W'(QTR) : angle_i;
    quad_c    = eff_c[ANGLE_W-1:ANGLE_W-2];
    idx_c     = eff_c[QTR_W-1:0];
    s1_vld_d  = in_valid_i;
    s1_tag_d  = in_valid_i ? in_tag_i : '0;
    s1_neg_d  = quad_c[1];
    s1_addr_d = quad_c[0] ? ADDR_W'(QTR) - ADDR_W'(idx_c) : ADDR_W'(idx_c);
  end

  always_comb begin
    s2_vld_d   = s1_vld_q;
    s2_tag_d   = s1_tag_q;
    s2_neg_d   = s1_neg_q;
    s2_mag_d   = rom[s1_addr_q];
    out_tag_d  = s2_tag_q;
    out_data_d = out_data_q;
    if (s2_vld_q) out_data_d = s2_neg_q ? -s2_mag_q : s2_mag_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q   <= 1'b0;
      s1_tag_q   <= '0;
      s1_neg_q   <= 1'b0;
      s1_addr_q  <= '0;
      s2_vld_q   <= 1'b0;
      s2_tag_q   <= '0;
      s2_neg_q   <= 1'b0;
      s2_mag_q   <= '0;
      out_tag_q  <= '0;
      out_data_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_tag_q   <= s1_tag_d;
      s1_neg_q   <= s1_neg_d;
      s1_addr_q  <= s1_addr_d;
      s2_vld_q   <= s2_vld_d;
      s2_tag_q   <= s2_tag_d;
      s2_neg_q   <= s2_neg_d;
      s2_mag_q   <= s2_mag_d;
      out_tag_q  <= out_tag_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_tag_o  = out_tag_q;
  assign out_data_o = out_data_q;
  assign busy_o     = s1_vld_q | s2_vld_q;

endmodule

// File: rtl/trig_arbiter.sv
// Round-robin front end sharing one trig_lut among NREQ requesters; the one-hot
// grant rides the pipeline as the response tag.
module trig_arbiter
  import trig_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*ANGLE_W-1:0]   req_angle,
  input  logic [NREQ-1:0]           req_is_cos,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           rsp_valid,
  output logic signed [DATA_W-1:0]  rsp_data,
  output logic                      busy
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_c;
  logic [PTR_W-1:0]   cand_c;
  logic               found_c;
  logic [NREQ-1:0]    grant_c;
  logic [ANGLE_W-1:0] sel_angle_c;
  logic               sel_cos_c;

  // First valid requester at or after the pointer, wrapping
  always_comb begin
    grant_c = '0;
    win_c   = '0;
    cand_c  = '0;
    found_c = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand_c = PTR_W'((int'(ptr_q) + k) % int'(NREQ));
      if (!found_c && req_valid[cand_c]) begin
        found_c         = 1'b1;
        win_c           = cand_c;
        grant_c[cand_c] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found_c) ptr_d = (int'(win_c) == int'(NREQ) - 1) ? '0 : win_c + PTR_W'(1);
  end

  always_comb begin
    sel_angle_c = '0;
    sel_cos_c   = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_c[i]) begin
        sel_angle_c = req_angle[ANGLE_W*i +: ANGLE_W];
        sel_cos_c   = req_is_cos[i];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign req_ready = grant_c;

  trig_lut #(
    .TAG_W (NREQ)
  ) u_lut (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .in_valid_i (found_c),
    .in_tag_i   (grant_c),
    .angle_i    (sel_angle_c),
    .is_cos_i   (sel_cos_c),
    .out_tag_o  (rsp_valid),
    .out_data_o (rsp_data),
    .busy_o     (busy)
  );

endmodule

// File: tb/tb_trig_arbiter.sv
// Directed bench for trig_arbiter: arbitration order, latency, angle folding and reset.
module tb_trig_arbiter;
  import trig_pkg::*;

  localparam int unsigned NREQ = 4;

  logic                      Clk;
  logic                      Reset_n;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ*ANGLE_W-1:0]   req_angle;
  logic [NREQ-1:0]           req_is_cos;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0]           rsp_valid;
  logic signed [DATA_W-1:0]  rsp_data;
  logic                      busy;

  int n_checks = 0;
  int n_pass   = 0;

  trig_arbiter #(.NREQ(NREQ)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .req_valid  (req_valid),
    .req_angle  (req_angle),
    .req_is_cos (req_is_cos),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ANGLE_W-1:0] a, input logic c);
    req_angle[ANGLE_W*i +: ANGLE_W] = a;
    req_is_cos[i] = c;
  endtask

  task automatic test_reset();
    Reset_n    = 1'b0;
    req_valid  = '0;
    req_angle  = '0;
    req_is_cos = '0;
    repeat (2) tick();
    n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); else n_pass++;
    n_checks++; if (int'(rsp_data) !== 0) $display("FAIL reset_rsp_data: got %0d want 0", rsp_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fairness();
    int exp_v [4] = '{0, 1024, 0, -1024};
    for (int i = 0; i < 4; i++) set_req(i, ANGLE_W'(256 * i), 1'b0);
    for (int c = 0; c < 14; c++) begin
      if (c < 12) begin
        req_valid = 4'hF;
        #1;
        n_checks++;
        if (req_ready !== 4'(1 << (c % 4)))
          $display("FAIL rr_grant c=%0d: got %b want %b", c, req_ready, 4'(1 << (c % 4)));
        else n_pass++;
      end else begin
        req_valid = '0;
      end
      tick();
      if (c >= 2) begin
        n_checks++;
        if (rsp_valid !== 4'(1 << ((c - 2) % 4)))
          $display("FAIL rr_rsp_tag c=%0d: got %b want %b", c, rsp_valid, 4'(1 << ((c - 2) % 4)));
        else n_pass++;
        n_checks++;
        if (int'(rsp_data) !== exp_v[(c - 2) % 4])
          $display("FAIL rr_rsp_data c=%0d: got %0d want %0d", c, rsp_data, exp_v[(c - 2) % 4]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_single();
    logic [ANGLE_W-1:0] ang [4] = '{10'd256, 10'd512, 10'd768, 10'd128};
    int exp_v [4] = '{1024, 0, -1024, 724};
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        set_req(REQ_PLAYER, ang[c], 1'b0);
        req_valid = 4'b0001;
        #1;
        n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready c=%0d: got %b want 0001", c, req_ready); else n_pass++;
      end else begin
        req_valid = '0;
      end
      tick();
      if (c == 0) begin
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
        n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL single_early_edge0: got %b want 0000", rsp_valid); else n_pass++;
      end else if (c == 1) begin
        n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL single_early_edge1: got %b want 0000", rsp_valid); else n_pass++;
      end else begin
        n_checks++; if (rsp_valid !== 4'b0001) $display("FAIL single_tag c=%0d: got %b want 0001", c, rsp_valid); else n_pass++;
        n_checks++; if (int'(rsp_data) !== exp_v[c - 2]) $display("FAIL single_data c=%0d: got %0d want %0d", c, rsp_data, exp_v[c - 2]); else n_pass++;
      end
    end
    tick();
    n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL single_drain_valid: got %b want 0000", rsp_valid); else n_pass++;
    n_checks++; if (int'(rsp_data) !== 724) $display("FAIL single_hold_data: got %0d want 724", rsp_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_drain_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_cos_back_to_back();
    logic [ANGLE_W-1:0] ang [3] = '{10'd0, 10'd512, 10'd1023};
    int exp_v [3] = '{1024, -1024, 1024};
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        set_req(REQ_SPOKES, ang[c], 1'b1);
        req_valid = 4'b0100;
        #1;
        n_checks++; if (req_ready !== 4'b0100) $display("FAIL cos_ready c=%0d: got %b want 0100", c, req_ready); else n_pass++;
      end else begin
        req_valid = '0;
      end
      tick();
      if (c >= 2) begin
        n_checks++; if (rsp_valid !== 4'b0100) $display("FAIL cos_tag c=%0d: got %b want 0100", c, rsp_valid); else n_pass++;
        n_checks++; if (int'(rsp_data) !== exp_v[c - 2]) $display("FAIL cos_data c=%0d: got %0d want %0d", c, rsp_data, exp_v[c - 2]); else n_pass++;
      end
    end
    set_req(REQ_SPOKES, 10'd0, 1'b0);
  endtask

  task automatic test_ptr_skip();
    logic [3:0] vpat  [8] = '{4'b0010, 4'b1001, 4'b1001, 4'b1001, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] gpat  [8] = '{4'b0010, 4'b1000, 4'b0001, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    int         dpat  [8] = '{0, -1024, 724, -1024, -1024, 0, 0, 0};
    set_req(REQ_PLAYER, 10'd128, 1'b0);
    set_req(REQ_WALLS,  10'd0,   1'b0);
    set_req(REQ_SPARE,  10'd768, 1'b0);
    for (int c = 0; c < 8; c++) begin
      req_valid = vpat[c];
      #1;
      n_checks++; if (req_ready !== gpat[c]) $display("FAIL skip_grant c=%0d: got %b want %b", c, req_ready, gpat[c]); else n_pass++;
      tick();
      if (c >= 2) begin
        n_checks++; if (rsp_valid !== gpat[c - 2]) $display("FAIL skip_tag c=%0d: got %b want %b", c, rsp_valid, gpat[c - 2]); else n_pass++;
        if (gpat[c - 2] != 4'b0000) begin
          n_checks++; if (int'(rsp_data) !== dpat[c - 2]) $display("FAIL skip_data c=%0d: got %0d want %0d", c, rsp_data, dpat[c - 2]); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    set_req(REQ_WALLS,  10'd256, 1'b0);
    set_req(REQ_SPOKES, 10'd768, 1'b0);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    #2;
    Reset_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL midrst_valid: got %b want 0000", rsp_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (int'(rsp_data) !== 0) $display("FAIL midrst_data: got %0d want 0", rsp_data); else n_pass++;
    #1;
    Reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL midrst_no_rsp c=%0d: got %b want 0000", c, rsp_valid); else n_pass++;
    end
    set_req(REQ_PLAYER, 10'd128, 1'b0);
    req_valid = 4'b1001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL midrst_ptr: got %b want 0001", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    repeat (2) tick();
    n_checks++; if (rsp_valid !== 4'b0001) $display("FAIL midrst_post_tag: got %b want 0001", rsp_valid); else n_pass++;
    n_checks++; if (int'(rsp_data) !== 724) $display("FAIL midrst_post_data: got %0d want 724", rsp_data); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_cos_back_to_back();
    test_ptr_skip();
    test_reset_midflight();
    repeat (LAT) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
